bitstream_decoder: RTL and testbench
====================================

BITSTREAM_DECODER -- requirements
Module: bitstream_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning log2 of the sample window (window N = 2^WIDTH cycles).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin one conversion window.
REQ-005 SHALL have port x  input  1  stochastic bitstream input bit.
REQ-006 SHALL have port busy  output  1  high while a window is being accumulated.
REQ-007 SHALL have port value  output  WIDTH+2  decoded result.
REQ-008 SHALL have port valid  output  1  result available.
REQ-009 SHALL have port ready  input  1  consumer accepts the result.

Function
REQ-010 SHALL implement states IDLE, ACCUM and HOLD, with IDLE as the reset state.
REQ-011 IDLE: busy=0, valid=0; start=1 SHALL go to ACCUM next cycle and clear the ones-counter and sample-counter.
REQ-012 ACCUM: each cycle SHALL add x to the ones-counter and increment the sample-counter; busy=1.
REQ-013 Start registered at edge t SHALL cause x to be sampled on edges t+1 .. t+N inclusive, exactly N samples.
REQ-014 After the Nth sample, SHALL go to HOLD with value registered and valid=1 from edge t+N+1; latency from start to valid is N+1 cycles.
REQ-015 The ones-counter SHALL be WIDTH+1 bits, SHALL hold 0..N, and SHALL never wrap.
REQ-016 The sample-counter SHALL be WIDTH bits and SHALL terminate the window when it wraps from N-1.
REQ-017 start SHALL be ignored in ACCUM, and in HOLD unless ready=1.
REQ-018 HOLD: value and valid SHALL remain stable until valid&ready; on handshake, SHALL go to IDLE, valid=0 next cycle.
REQ-019 Handshake with start=1 in the same cycle SHALL go directly to ACCUM (counters cleared, valid=0), giving back-to-back windows with no IDLE cycle.
REQ-020 value SHALL only change on entry to HOLD or on reset.

Reset
REQ-021 rst=1 at any edge SHALL force IDLE, busy=0, valid=0, value=0, and counters=0, overriding all other inputs.
REQ-022 Reset during ACCUM or HOLD SHALL discard the partial or pending result; no valid SHALL follow.

Configuration
REQ-023 Macro DECODER_BIPOLAR_EN SHALL select the output encoding.
REQ-024 Without DECODER_BIPOLAR_EN, value SHALL equal the ones-count zero-extended (unsigned, 0..N).
REQ-025 With DECODER_BIPOLAR_EN, value SHALL equal 2*ones - N as two's-complement signed (-N..+N).
REQ-026 In both modes, value width SHALL be WIDTH+2, and latency and handshake SHALL be identical.

Verification (WIDTH=4, N=16)
REQ-027 SHALL cover: x=1 for all 16 samples -> valid at start+17, value=16 unipolar / +16 bipolar.
REQ-028 SHALL cover: x=0 for all samples -> value=0 unipolar / -16 (6'b110000) bipolar.
REQ-029 SHALL cover: x alternating 1,0,... for 16 samples -> value=8 unipolar / 0 bipolar.
REQ-030 SHALL cover: ready held low 5 cycles after valid, start pulsed and x toggled meanwhile -> value and valid unchanged; one handshake then valid=0.
REQ-031 SHALL cover: rst pulsed at the 9th ACCUM cycle -> busy=0, value=0 next cycle, no valid for 20 following cycles without start.
REQ-032 SHALL cover: start=1 coincident with valid&ready, second window all ones -> busy=1 next cycle, second valid 17 cycles after handshake, value=16 unipolar.

Source files
------------

// File: rtl/bitstream_decoder.sv
// Stochastic bitstream decoder: counts ones over a 2^WIDTH-cycle window.
// Define DECODER_BIPOLAR_EN for signed 2*ones-N output instead of raw count.
module bitstream_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             x,
  input  logic             ready,
  output logic             busy,
  output logic [WIDTH+1:0] value,
  output logic             valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [WIDTH+1:0] N_EXT =
    {2'b01, {WIDTH{1'b0}}};

  state_t           state;
  logic [WIDTH:0]   ones;
  logic [WIDTH-1:0] cnt;
  logic             done;

  function automatic logic [WIDTH+1:0] encode(
    input logic [WIDTH:0] o
  );
`ifdef DECODER_BIPOLAR_EN
    return {o, 1'b0} - N_EXT;
`else
    return {1'b0, o};
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ones  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      valid <= 1'b0;
      value <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= ACCUM;
            ones  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          // done marks the Nth sample taken; next edge publishes it
          if (!done) begin
            ones <= ones + {{WIDTH{1'b0}}, x};
            cnt  <= cnt + WIDTH'(1);
            if (cnt == '1)
              done <= 1'b1;
          end else begin
            state <= HOLD;
            value <= encode(ones);
            valid <= 1'b1;
            busy  <= 1'b0;
          end
        end
        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            if (start) begin
              state <= ACCUM;
              ones  <= '0;
              cnt   <= '0;
              done  <= 1'b0;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// Directed bench for bitstream_decoder, WIDTH=4 (N=16).
// Follows DECODER_BIPOLAR_EN to pick expected encodings.
module tb_bitstream_decoder;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         x;
  logic         ready;
  logic         busy;
  logic [W+1:0] value;
  logic         valid;

  int n_vec;
  int n_err;

  bitstream_decoder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .ready(ready),
    .busy (busy),
    .value(value),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [15:0]  pat;
    logic [W+1:0] uni;
    logic [W+1:0] bip;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string        nm,
    input logic [W+1:0] got,
    input logic [W+1:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic logic [W+1:0] pick(
    input logic [W+1:0] u,
    input logic [W+1:0] b
  );
`ifdef DECODER_BIPOLAR_EN
    return b;
`else
    return u;
`endif
  endfunction

  // start at next edge, feed 16 samples, check latency and result
  task automatic window(
    input string        nm,
    input logic [15:0]  pat,
    input logic [W+1:0] exp
  );
    start = 1'b1;
    step();
    start = 1'b0;
    check({nm, "_busy"}, {5'd0, busy}, 6'd1);
    for (int i = 0; i < 16; i++) begin
      x = pat[i];
      step();
    end
    x = 1'b0;
    check({nm, "_early"}, {5'd0, valid}, 6'd0);
    step();
    check({nm, "_valid"}, {5'd0, valid}, 6'd1);
    check({nm, "_value"}, value, exp);
    check({nm, "_idle"}, {5'd0, busy}, 6'd0);
  endtask

  task automatic handshake(input string nm);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check({nm, "_hs"}, {5'd0, valid}, 6'd0);
  endtask

  logic [W+1:0] held;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start = 1'b0;
    x     = 1'b0;
    ready = 1'b0;

    tbl[0] = '{"ones",  16'hFFFF, 6'd16, 6'd16};
    tbl[1] = '{"zeros", 16'h0000, 6'd0,  6'b110000};
    tbl[2] = '{"alt",   16'h5555, 6'd8,  6'd0};
    tbl[3] = '{"top4",  16'hF000, 6'd4,  6'b111000};
    tbl[4] = '{"one",   16'h0001, 6'd1,  6'b110010};
    tbl[5] = '{"ones15",16'h7FFF, 6'd15, 6'd14};

    step();
    step();
    rst = 1'b0;
    check("rst_busy", {5'd0, busy}, 6'd0);
    check("rst_valid", {5'd0, valid}, 6'd0);
    check("rst_value", value, 6'd0);

    for (int k = 0; k < 6; k++) begin
      window(tbl[k].name, tbl[k].pat,
             pick(tbl[k].uni, tbl[k].bip));
      handshake(tbl[k].name);
      check({tbl[k].name, "_post"},
            {5'd0, busy}, 6'd0);
    end

    // result held while ready low, start/x ignored
    window("hold", 16'h5555, pick(6'd8, 6'd0));
    held = pick(6'd8, 6'd0);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      x = i[0];
      step();
      check("hold_valid", {5'd0, valid}, 6'd1);
      check("hold_value", value, held);
      check("hold_busy", {5'd0, busy}, 6'd0);
    end
    start = 1'b0;
    x = 1'b0;
    handshake("hold");
    step();
    check("hold_after", {5'd0, valid}, 6'd0);
    check("hold_nobusy", {5'd0, busy}, 6'd0);

    // back-to-back windows via start during handshake
    window("b2b1", 16'h00F0, pick(6'd4, 6'b111000));
    ready = 1'b1;
    start = 1'b1;
    step();
    ready = 1'b0;
    start = 1'b0;
    check("b2b_busy", {5'd0, busy}, 6'd1);
    check("b2b_valid0", {5'd0, valid}, 6'd0);
    for (int i = 0; i < 16; i++) begin
      x = 1'b1;
      step();
    end
    x = 1'b0;
    check("b2b_early", {5'd0, valid}, 6'd0);
    step();
    check("b2b_valid", {5'd0, valid}, 6'd1);
    check("b2b_value", value, 6'd16);
    handshake("b2b");

    // reset mid-window drops the partial result
    start = 1'b1;
    step();
    start = 1'b0;
    x = 1'b1;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    x = 1'b0;
    check("mrst_busy", {5'd0, busy}, 6'd0);
    check("mrst_value", value, 6'd0);
    check("mrst_valid", {5'd0, valid}, 6'd0);
    for (int i = 0; i < 20; i++) begin
      x = i[0];
      step();
      check("mrst_novalid", {5'd0, valid}, 6'd0);
      check("mrst_nobusy", {5'd0, busy}, 6'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
